// File: rtl/seg_pkg.sv
// Shared types for the seven-segment display controller: framebuffer entry
// layout and the word-load FSM states.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       en;
  } fb_entry_t;

  typedef enum logic {StIdle, StLoad} state_e;

endpackage

// File: rtl/seg_rr_arb.sv
// Two-way round-robin arbiter with combinational one-hot grants; priority
// toggles to the other port after every grant.
module seg_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // prio_q == 0: port 0 wins a tie
  logic prio_q, prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0])      prio_d = 1'b1;
    else if (gnt_o[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Eight-digit framebuffer for a scanned seven-segment driver, written either a
// whole word at a time (with leading-zero blanking) or one digit at a time.
module seg_display_ctrl
  import seg_pkg::*;
(
  input  logic        clk_100mhz,
  input  logic        nrst,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic [7:0]  word_dp,
  input  logic        word_blank,
  input  logic        dig_valid,
  output logic        dig_ready,
  input  logic [2:0]  dig_idx,
  input  logic [3:0]  dig_val,
  input  logic        dig_dp,
  input  logic        dig_en,
  input  logic        clr,
  input  logic [2:0]  can,
  output logic [3:0]  val,
  output logic        d,
  output logic        valid,
  output logic        busy
);

  state_e                        state_q, state_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic                          lead_q, lead_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic [7:0]                    wdp_q, wdp_d;
  logic                          wblank_q, wblank_d;
  fb_entry_t [NUM_DIGITS-1:0]    fb_q, fb_d;

  logic [1:0] gnt;
  logic       arb_en;
  logic       word_hs, dig_hs;
  logic [3:0] nib;
  logic       nib_blank;

  assign arb_en = nrst && !clr && (state_q == StIdle);

  seg_rr_arb u_arb (
    .clk_i  (clk_100mhz),
    .rst_ni (nrst),
    .en_i   (arb_en),
    .req_i  ({dig_valid, word_valid}),
    .gnt_o  (gnt)
  );

  assign word_ready = gnt[0];
  assign dig_ready  = gnt[1];
  assign word_hs    = word_valid && word_ready;
  assign dig_hs     = dig_valid && dig_ready;

  // Digit 0 is never blanked so an all-zero word still shows a single 0.
  assign nib       = wdata_q[{cnt_q, 2'b00} +: 4];
  assign nib_blank = wblank_q && lead_q && (nib == 4'h0) && (cnt_q != 3'd0);

  always_ff @(posedge clk_100mhz) begin
    if (!nrst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (word_hs) state_d = StLoad;
      StLoad:  if (cnt_q == 3'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_comb begin
    busy = (state_q == StLoad);
  end

  always_comb begin
    fb_d     = fb_q;
    cnt_d    = cnt_q;
    lead_d   = lead_q;
    wdata_d  = wdata_q;
    wdp_d    = wdp_q;
    wblank_d = wblank_q;
    if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) fb_d[i].en = 1'b0;
    end else if (state_q == StLoad) begin
      fb_d[cnt_q] = '{val: nib, dp: wdp_q[cnt_q], en: !nib_blank};
      if (!nib_blank) lead_d = 1'b0;
      cnt_d = cnt_q - 3'd1;
    end else begin
      if (word_hs) begin
        wdata_d  = word_data;
        wdp_d    = word_dp;
        wblank_d = word_blank;
        cnt_d    = 3'd7;
        lead_d   = 1'b1;
      end
      if (dig_hs) fb_d[dig_idx] = '{val: dig_val, dp: dig_dp, en: dig_en};
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!nrst) begin
      fb_q     <= '0;
      cnt_q    <= '0;
      lead_q   <= 1'b0;
      wdata_q  <= '0;
      wdp_q    <= '0;
      wblank_q <= 1'b0;
    end else begin
      fb_q     <= fb_d;
      cnt_q    <= cnt_d;
      lead_q   <= lead_d;
      wdata_q  <= wdata_d;
      wdp_q    <= wdp_d;
      wblank_q <= wblank_d;
    end
  end

  assign val   = fb_q[can].val;
  assign d     = fb_q[can].dp;
  assign valid = fb_q[can].en;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: word loads, digit writes, arbitration,
// clear and reset behaviour with hand-computed framebuffer images.
module tb_seg_display_ctrl;

  logic        clk_100mhz, nrst;
  logic        word_valid, word_ready, word_blank;
  logic [31:0] word_data;
  logic [7:0]  word_dp;
  logic        dig_valid, dig_ready, dig_dp, dig_en;
  logic [2:0]  dig_idx, can;
  logic [3:0]  dig_val, val;
  logic        clr, d, valid, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;
  logic [5:0] exp_fb [8];  // {val, dp, en} per digit
  logic [5:0] rd;

  seg_display_ctrl dut (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_dp    (word_dp),
    .word_blank (word_blank),
    .dig_valid  (dig_valid),
    .dig_ready  (dig_ready),
    .dig_idx    (dig_idx),
    .dig_val    (dig_val),
    .dig_dp     (dig_dp),
    .dig_en     (dig_en),
    .clr        (clr),
    .can        (can),
    .val        (val),
    .d          (d),
    .valid      (valid),
    .busy       (busy)
  );

  initial clk_100mhz = 1'b0;
  always #20 clk_100mhz = ~clk_100mhz;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_dig(input int i, output logic [5:0] e);
    can = 3'(i);
    #1;
    e = {val, d, valid};
  endtask

  task automatic check_fb(input string tag);
    logic [5:0] e;
    for (int i = 0; i < 8; i++) begin
      read_dig(i, e);
      check_eq($sformatf("%s dig%0d", tag, i), 32'(e), 32'(exp_fb[i]));
    end
  endtask

  task automatic word_load(input logic [31:0] data, input logic [7:0] dp, input logic blank,
                           output int n_busy);
    int n;
    word_data  = data;
    word_dp    = dp;
    word_blank = blank;
    word_valid = 1'b1;
    #1;
    n = 0;
    while (!word_ready && n < 20) begin
      @(posedge clk_100mhz); #1;
      n++;
    end
    check_eq("word grant", 32'(word_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    word_valid = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 20) begin
      @(posedge clk_100mhz); #1;
      n_busy++;
    end
  endtask

  initial begin
    nrst = 1'b0; clr = 1'b0; can = '0;
    word_valid = 1'b0; word_data = '0; word_dp = '0; word_blank = 1'b0;
    dig_valid = 1'b0; dig_idx = '0; dig_val = '0; dig_dp = 1'b0; dig_en = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;

    // Reset state: no grants while nrst low, empty framebuffer
    word_valid = 1'b1; dig_valid = 1'b1;
    #1;
    check_eq("rst word_ready", 32'(word_ready), 32'd0);
    check_eq("rst dig_ready", 32'(dig_ready), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    word_valid = 1'b0; dig_valid = 1'b0;
    exp_fb = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    check_fb("rst");
    @(posedge clk_100mhz); #1;
    nrst = 1'b1;

    // Simultaneous word + digit request: word wins, digit waits out LOAD
    word_data = 32'h0000_12AB; word_dp = 8'h04; word_blank = 1'b1; word_valid = 1'b1;
    dig_idx = 3'd5; dig_val = 4'h7; dig_dp = 1'b0; dig_en = 1'b1; dig_valid = 1'b1;
    #1;
    check_eq("tie word_ready", 32'(word_ready), 32'd1);
    check_eq("tie dig_ready", 32'(dig_ready), 32'd0);
    @(posedge clk_100mhz); #1;
    word_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      check_eq("load dig_ready", 32'(dig_ready), 32'd0);
      @(posedge clk_100mhz); #1;
      cycles++;
    end
    check_eq("load busy cycles", 32'(cycles), 32'd8);
    check_eq("idle dig_ready", 32'(dig_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    dig_valid = 1'b0;
    exp_fb = '{6'h2D, 6'h29, 6'h0B, 6'h05, 6'h00, 6'h1D, 6'h00, 6'h00};
    check_fb("w12AB+d5");

    // All-zero word with and without blanking; tie after a word grant goes to digit
    word_load(32'h0, 8'h00, 1'b1, cycles);
    check_eq("zero blank cycles", 32'(cycles), 32'd8);
    exp_fb = '{6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    check_fb("zero blank");
    word_data = 32'h0; word_dp = 8'h00; word_blank = 1'b0; word_valid = 1'b1;
    dig_idx = 3'd6; dig_val = 4'h3; dig_en = 1'b1; dig_valid = 1'b1;
    #1;
    check_eq("rr word_ready", 32'(word_ready), 32'd0);
    check_eq("rr dig_ready", 32'(dig_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    dig_valid = 1'b0;
    read_dig(6, rd);
    check_eq("rr dig6", 32'(rd), 32'h0D);
    word_load(32'h0, 8'h00, 1'b0, cycles);
    check_eq("zero noblank cycles", 32'(cycles), 32'd8);
    exp_fb = '{6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01};
    check_fb("zero noblank");

    // clr in the 4th LOAD cycle
    word_load(32'h1111_1111, 8'h00, 1'b0, cycles);
    exp_fb = '{6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05};
    check_fb("ones");
    word_data = 32'h7654_3210; word_valid = 1'b1;
    #1;
    check_eq("clr word grant", 32'(word_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    word_valid = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    clr = 1'b1;
    dig_idx = 3'd0; dig_val = 4'h5; dig_en = 1'b1; dig_valid = 1'b1; word_valid = 1'b1;
    @(posedge clk_100mhz); #1;
    check_eq("clr busy", 32'(busy), 32'd0);
    check_eq("clr idle word_ready", 32'(word_ready), 32'd0);
    check_eq("clr idle dig_ready", 32'(dig_ready), 32'd0);
    exp_fb = '{6'h04, 6'h04, 6'h04, 6'h04, 6'h04, 6'h14, 6'h18, 6'h1C};
    check_fb("clr");
    clr = 1'b0;
    #1;
    check_eq("post-clr word_ready", 32'(word_ready), 32'd0);
    check_eq("post-clr dig_ready", 32'(dig_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    dig_valid = 1'b0; word_valid = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    exp_fb = '{6'h15, 6'h04, 6'h04, 6'h04, 6'h04, 6'h14, 6'h18, 6'h1C};
    check_fb("post-clr");

    // Reset in the middle of LOAD
    word_data = 32'hFEDC_BA98; word_valid = 1'b1;
    #1;
    check_eq("rst-load grant", 32'(word_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    word_valid = 1'b0;
    @(posedge clk_100mhz); #1;
    nrst = 1'b0; word_valid = 1'b1;
    #1;
    check_eq("nrst word_ready", 32'(word_ready), 32'd0);
    @(posedge clk_100mhz); #1;
    word_valid = 1'b0;
    check_eq("nrst busy", 32'(busy), 32'd0);
    exp_fb = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    check_fb("nrst");
    nrst = 1'b1;
    word_load(32'h0000_12AB, 8'h04, 1'b1, cycles);
    check_eq("after-rst cycles", 32'(cycles), 32'd8);
    exp_fb = '{6'h2D, 6'h29, 6'h0B, 6'h05, 6'h00, 6'h00, 6'h00, 6'h00};
    check_fb("after-rst");

    // Back-to-back digit writes on idx 3
    dig_idx = 3'd3; dig_val = 4'h9; dig_dp = 1'b0; dig_en = 1'b1; dig_valid = 1'b1;
    #1;
    check_eq("b2b grant1", 32'(dig_ready), 32'd1);
    read_dig(3, rd);
    check_eq("b2b before", 32'(rd), 32'h05);
    @(posedge clk_100mhz); #1;
    read_dig(3, rd);
    check_eq("b2b first", 32'(rd), 32'h25);
    dig_en = 1'b0;
    #1;
    check_eq("b2b grant2", 32'(dig_ready), 32'd1);
    @(posedge clk_100mhz); #1;
    dig_valid = 1'b0;
    read_dig(3, rd);
    check_eq("b2b second", 32'(rd), 32'h24);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
